// File: rtl/seq_mult4_pkg.sv
// seq_mult4_pkg: shared types and constants for the sequential 4x4 multiplier
package seq_mult4_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int N = 4;
  localparam int ITERS = 4;
  localparam int PW = 2 * N;
endpackage

// File: rtl/four_bit_RCA_RCS.sv
// four_bit_RCA_RCS: 4-bit ripple-carry adder/subtractor; Cin=1 subtracts B
module four_bit_RCA_RCS
  import seq_mult4_pkg::*;
(
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);
  logic [N:0]   w_c;
  logic [N-1:0] w_b;
  assign w_c[0] = Cin;
  for (genvar g = 0; g < N; g++) begin : g_fa
    assign w_b[g]   = B[g] ^ Cin;
    assign S[g]     = A[g] ^ w_b[g] ^ w_c[g];
    assign w_c[g+1] = (A[g] & w_b[g]) | (w_c[g] & (A[g] ^ w_b[g]));
  end
  assign Cout = w_c[N];
endmodule

// File: rtl/seq_mult4.sv
// seq_mult4: shift-add 4x4 unsigned multiplier; one partial product per cycle
// through the shared ripple adder, start/busy/done handshake.
module seq_mult4
  import seq_mult4_pkg::*;
#(
  parameter int N = seq_mult4_pkg::N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  state_t         r_state;
  logic [N-1:0]   r_m, r_q, r_a;
  logic [1:0]     r_cnt;
  logic           r_busy, r_done;
  logic [2*N-1:0] r_product;
  logic [N-1:0]   w_s, w_sel_s, w_a_next, w_q_next;
  logic           w_c, w_sel_c;

  four_bit_RCA_RCS u_rca (
    .A   (r_a),
    .B   (r_m),
    .Cin (1'b0),
    .S   (w_s),
    .Cout(w_c)
  );

  // Skip the add when the current multiplier bit is 0; carry lands in A's MSB.
  assign w_sel_s  = r_q[0] ? w_s : r_a;
  assign w_sel_c  = r_q[0] & w_c;
  assign w_a_next = {w_sel_c, w_sel_s[N-1:1]};
  assign w_q_next = {w_sel_s[0], r_q[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_a       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_m     <= a_in;
          r_q     <= b_in;
          r_a     <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'(ITERS - 1)) begin
            r_product <= {w_a_next, w_q_next};
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
endmodule
